// File: rtl/pchb_req_driver.sv
// Clocked four-phase RZ initiator for a PCHB stage: accepts operands on valid/ready, drives a/b/en/req.
// Returns the captured result on valid/ready. in_ready stays low until the result is drained.
module pchb_req_driver #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             en,
  output logic             req,
  input  logic             ack,
  input  logic [WIDTH-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             busy,
  output logic             timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    REQ_HI = 3'd2,
    REQ_LO = 3'd3,
    RESULT = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [TW-1:0]          timer;
  logic                   timed_out;

  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign timed_out = (timer == TW'(TIMEOUT));

  // ack comes straight from the asynchronous stage; only the last flop is trusted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      a           <= '0;
      b           <= '0;
      en          <= 1'b0;
      req         <= 1'b0;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      timer       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a        <= in_a;
            b        <= in_b;
            en       <= 1'b1;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            state    <= SETUP;
          end
        end
        // one cycle of data setup on a/b before req rises
        SETUP: begin
          req   <= 1'b1;
          timer <= '0;
          state <= REQ_HI;
        end
        REQ_HI: begin
          if (ack_s) begin
            out_sum <= sum;
            req     <= 1'b0;
            timer   <= '0;
            state   <= REQ_LO;
          end else if (timed_out) begin
            req         <= 1'b0;
            en          <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ERR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            en        <= 1'b0;
            out_valid <= 1'b1;
            state     <= RESULT;
          end else if (timed_out) begin
            en          <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ERR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        // sticky: only reset_n leaves this state
        ERR: begin
          req <= 1'b0;
          en  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pchb_req_driver.sv
// Bench for pchb_req_driver: behavioural four-phase responder plus a queue of expected sums.
module tb_pchb_req_driver;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int TO   = 20;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         en;
  logic         req;
  logic         ack = 1'b0;
  logic [W-1:0] sum = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         busy;
  logic         timeout_err;

  pchb_req_driver #(.WIDTH(W), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .a(a), .b(b), .en(en), .req(req), .ack(ack), .sum(sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Responder: the stage under the bundled-data protocol, waiting resp_dly cycles per phase
  int resp_dly  = 2;
  bit stick_ack = 1'b0;
  int rcnt      = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        ack  = 1'b0;
        rcnt = 0;
      end else if (req && !ack) begin
        if (rcnt >= resp_dly) begin
          sum  = a + b;
          ack  = 1'b1;
          rcnt = 0;
        end else rcnt++;
      end else if (!req && ack && !stick_ack) begin
        if (rcnt >= resp_dly) begin
          ack  = 1'b0;
          rcnt = 0;
        end else rcnt++;
      end else begin
        rcnt = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input bit chk_lat);
    int n;
    in_a = va;
    in_b = vb;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(W'((int'(va) + int'(vb)) % (1 << W)));
    if (chk_lat) begin
      check("setup_req", req, 0);
      check("setup_en", en, 1);
      check("hold_a", a, va);
      check("hold_b", b, vb);
      @(negedge clk);
      check("req_latency", req, 1);
    end
  endtask

  task automatic recv(input int pct);
    int n;
    bit done;
    logic [W-1:0] e;
    n = 0;
    done = 1'b0;
    out_ready = 1'b0;
    while (!done && n < 1000) begin
      if (out_valid && int'($urandom_range(99)) < pct) begin
        e = exp_q.pop_front();
        check("out_sum", out_sum, e);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain", out_valid, 0);
        done = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!done) check("result_wait", out_valid, 1);
  endtask

  task automatic wait_req(input logic lvl);
    int n;
    n = 0;
    while (req !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", req, lvl);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [W-1:0] ra, rb;

    // reset with in_valid asserted
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", req, 0);
    check("rst_en", en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", timeout_err, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_a", a, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    in_valid = 1'b0;

    // normal and wrap-around pairs
    send(4'd3, 4'd5, 1'b1);
    recv(100);
    send(4'd9, 4'd9, 1'b0);
    recv(100);
    send(4'd15, 4'd1, 1'b0);
    recv(100);

    // backpressure: result held, next pair waits
    send(4'd6, 4'd7, 1'b0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", out_valid, 1);
    in_a = 4'd1;
    in_b = 4'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_sum", out_sum, 13);
      check("bp_in_ready", in_ready, 0);
      check("bp_req", req, 0);
    end
    recv(100);
    send(4'd1, 4'd1, 1'b0);
    recv(100);

    // randomized traffic with varying stage delay and downstream readiness
    for (int t = 0; t < 40; t++) begin
      resp_dly = int'($urandom_range(5));
      ra = W'($urandom);
      rb = W'($urandom);
      send(ra, rb, (t % 8) == 0);
      recv(int'($urandom_range(100, 30)));
    end

    // asynchronous reset while the request is high
    resp_dly = 8;
    send(4'd7, 4'd7, 1'b0);
    wait_req(1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_req", req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_en", en, 0);
    check("mid_rst_in_ready", in_ready, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    resp_dly = 2;
    send(4'd2, 4'd4, 1'b0);
    recv(100);

    // ack stuck high: timeout in the return-to-zero phase
    stick_ack = 1'b1;
    resp_dly = 1;
    send(4'd4, 4'd4, 1'b0);
    wait_req(1'b1);
    wait_req(1'b0);
    n = 0;
    while (!timeout_err && n < 4 * TO) begin
      @(negedge clk);
      n++;
    end
    // timer runs 0..TO inside REQ_LO, so ERR is entered on the (TO+1)th edge
    check("timeout_cycles", n, TO + 1);
    check("to_out_sum", out_sum, 8);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("err_req", req, 0);
      check("err_in_ready", in_ready, 0);
      check("err_en", en, 0);
      check("err_sticky", timeout_err, 1);
      check("err_valid", out_valid, 0);
    end
    reset_n = 1'b0;
    in_valid = 1'b0;
    stick_ack = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("err_cleared", timeout_err, 0);
    check("err_busy", busy, 0);
    reset_n = 1'b1;
    send(4'd5, 4'd6, 1'b1);
    recv(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
